// File: rtl/imem_loader_arb_if.sv
// Bus bundle between the instruction-memory arbiter and its CPU fetch port,
// byte-stream program loader and single-port synchronous memory.
interface imem_loader_arb_if #(
    parameter int ADDR_W = 6
);
    logic [31:0]       cpu_pc;
    logic              cpu_req;
    logic              cpu_stall;
    logic              cpu_valid;
    logic [31:0]       cpu_instr;
    logic              cpu_fault;
    logic              ld_start;
    logic [ADDR_W:0]   ld_len;
    logic [7:0]        ld_byte;
    logic              ld_byte_valid;
    logic              ld_byte_ready;
    logic              ld_busy;
    logic              ld_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Arbiter side.
    modport master (
        input  cpu_pc, cpu_req, ld_start, ld_len, ld_byte, ld_byte_valid, mem_rdata,
        output cpu_stall, cpu_valid, cpu_instr, cpu_fault, ld_byte_ready, ld_busy,
               ld_done, mem_addr, mem_re, mem_we, mem_wdata
    );

    // CPU, loader and memory side.
    modport slave (
        output cpu_pc, cpu_req, ld_start, ld_len, ld_byte, ld_byte_valid, mem_rdata,
        input  cpu_stall, cpu_valid, cpu_instr, cpu_fault, ld_byte_ready, ld_busy,
               ld_done, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_loader_arb.sv
// Shares a single-port instruction memory between CPU fetches (1-cycle latency)
// and a loader that assembles little-endian words from a byte stream.
module imem_loader_arb #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] NOP_INSTR = 32'hE1A00000
) (
    input logic                clk,
    input logic                reset_n,
    imem_loader_arb_if.master  bus
);
    typedef enum logic [1:0] {RUN, ASSEMBLE, WRITE, DONE} state_e;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] word_idx_q, word_idx_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     word_q, word_d;
    logic            valid_q, fault_q;
    logic            ready_q, busy_q, done_q, we_q;

    logic            fetch_acc;
    logic            fetch_oor;
    logic [ADDR_W:0] word_idx_inc;

    // A load request wins over a same-cycle fetch.
    assign fetch_acc    = (state_q == RUN) && bus.cpu_req && !bus.ld_start;
    assign fetch_oor    = (bus.cpu_pc[31:ADDR_W+2] != '0) || (bus.cpu_pc[1:0] != 2'b00);
    assign word_idx_inc = word_idx_q + 1'b1;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        unique case (state_q)
            RUN: begin
                if (bus.ld_start) begin
                    len_d      = (bus.ld_len > DEPTH) ? DEPTH : bus.ld_len;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    word_d     = '0;
                    state_d    = (bus.ld_len == '0) ? DONE : ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                if (bus.ld_byte_valid && ready_q) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.ld_byte;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                word_idx_d = word_idx_inc;
                byte_cnt_d = '0;
                state_d    = (word_idx_inc == len_q) ? DONE : ASSEMBLE;
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Loader-side outputs are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            state_q    <= RUN;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            valid_q    <= fetch_acc;
            fault_q    <= fetch_acc && fetch_oor;
            ready_q    <= (state_d == ASSEMBLE);
            busy_q     <= (state_d != RUN);
            done_q     <= (state_d == DONE);
            we_q       <= (state_d == WRITE);
        end
    end

    always_comb begin
        bus.mem_addr = '0;
        if (state_q == RUN) bus.mem_addr = bus.cpu_pc[ADDR_W+1:2];
        else if (we_q)      bus.mem_addr = word_idx_q[ADDR_W-1:0];
    end

    assign bus.mem_re        = fetch_acc;
    assign bus.mem_we        = we_q;
    assign bus.mem_wdata     = we_q ? word_q : '0;
    assign bus.cpu_stall     = (state_q != RUN) || bus.ld_start;
    assign bus.cpu_valid     = valid_q;
    assign bus.cpu_fault     = fault_q;
    assign bus.cpu_instr     = valid_q ? (fault_q ? NOP_INSTR : bus.mem_rdata) : '0;
    assign bus.ld_byte_ready = ready_q;
    assign bus.ld_busy       = busy_q;
    assign bus.ld_done       = done_q;
endmodule

// File: tb/tb_imem_loader_arb.sv
// Directed bench for imem_loader_arb: a transaction-level model schedules the
// expected outputs of every cycle, and literal values pin the key scenarios.
module tb_imem_loader_arb;
    localparam int          AW  = 6;
    localparam int          NC  = 1024;
    localparam logic [31:0] NOP = 32'hE1A00000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_arb_if #(.ADDR_W(AW)) bus ();

    imem_loader_arb #(.ADDR_W(AW), .NOP_INSTR(NOP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'hE04F000F;
            1:       return 32'hE2800001;
            2:       return 32'hE1500001;
            default: return 32'hC0DE0000 | 32'(i);
        endcase
    endfunction

    // Synchronous single-port memory with one-cycle read latency.
    logic [31:0] sram [64];
    bit          sram_init = 1'b0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
            sram_init <= 1'b1;
        end else begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr];
        end
    end

    // Model: memory image plus per-cycle expected outputs.
    bit [31:0]   ref_mem   [64];
    bit          exp_valid [NC];
    bit [31:0]   exp_instr [NC];
    bit          exp_fault [NC];
    bit          exp_stall [NC];
    bit          exp_busy  [NC];
    bit          exp_done  [NC];
    bit          exp_ready [NC];
    bit          exp_re    [NC];
    bit          exp_we    [NC];
    bit [AW-1:0] exp_addr  [NC];
    bit [31:0]   exp_wdata [NC];

    // Observed values, for the literal checks.
    logic        obs_valid [NC];
    logic [31:0] obs_instr [NC];
    logic        obs_fault [NC];
    logic        obs_we    [NC];
    logic [31:0] obs_wdata [NC];
    int          we_total = 0;
    int          done_total = 0;
    int          last_done_cyc = -1;

    bit [7:0] src [256];
    int       cyc = 0;
    bit       chk_en = 1'b0;
    int       n_pass = 0;
    int       n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic compare_cycle();
        if (cyc >= NC) begin
            check("cycle_budget", 32'(cyc), 32'(NC - 1));
            $fatal(1, "cycle budget exhausted");
        end
        obs_valid[cyc] = bus.cpu_valid;
        obs_instr[cyc] = bus.cpu_instr;
        obs_fault[cyc] = bus.cpu_fault;
        obs_we[cyc]    = bus.mem_we;
        obs_wdata[cyc] = bus.mem_wdata;
        if (bus.mem_we === 1'b1) we_total++;
        if (bus.ld_done === 1'b1) begin
            done_total++;
            last_done_cyc = cyc;
        end
        check($sformatf("cpu_valid@%0d", cyc), 32'(bus.cpu_valid), 32'(exp_valid[cyc]));
        check($sformatf("cpu_instr@%0d", cyc), bus.cpu_instr, exp_instr[cyc]);
        check($sformatf("cpu_fault@%0d", cyc), 32'(bus.cpu_fault), 32'(exp_fault[cyc]));
        check($sformatf("cpu_stall@%0d", cyc), 32'(bus.cpu_stall), 32'(exp_stall[cyc]));
        check($sformatf("ld_busy@%0d", cyc), 32'(bus.ld_busy), 32'(exp_busy[cyc]));
        check($sformatf("ld_done@%0d", cyc), 32'(bus.ld_done), 32'(exp_done[cyc]));
        check($sformatf("ld_ready@%0d", cyc), 32'(bus.ld_byte_ready), 32'(exp_ready[cyc]));
        check($sformatf("mem_re@%0d", cyc), 32'(bus.mem_re), 32'(exp_re[cyc]));
        check($sformatf("mem_we@%0d", cyc), 32'(bus.mem_we), 32'(exp_we[cyc]));
        check($sformatf("re_we_excl@%0d", cyc), 32'(bus.mem_re & bus.mem_we), 32'd0);
        if (exp_re[cyc] || exp_we[cyc])
            check($sformatf("mem_addr@%0d", cyc), 32'(bus.mem_addr), 32'(exp_addr[cyc]));
        if (exp_we[cyc])
            check($sformatf("mem_wdata@%0d", cyc), bus.mem_wdata, exp_wdata[cyc]);
    endtask

    // Checks the current cycle, then advances to the next one with idle inputs.
    task automatic step();
        @(negedge clk);
        if (chk_en) compare_cycle();
        @(posedge clk);
        cyc++;
        #1;
        bus.cpu_req       = 1'b0;
        bus.cpu_pc        = '0;
        bus.ld_start      = 1'b0;
        bus.ld_len        = '0;
        bus.ld_byte       = '0;
        bus.ld_byte_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bit f;
        f = (pc[31:AW+2] != '0) || (pc[1:0] != 2'b00);
        bus.cpu_req = 1'b1;
        bus.cpu_pc  = pc;
        exp_re[cyc]     = 1'b1;
        exp_addr[cyc]   = pc[AW+1:2];
        exp_valid[cyc+1] = 1'b1;
        exp_fault[cyc+1] = f;
        exp_instr[cyc+1] = f ? NOP : ref_mem[pc[AW+1:2]];
        step();
    endtask

    task automatic mark_load(input bit ready);
        exp_busy[cyc]  = 1'b1;
        exp_stall[cyc] = 1'b1;
        exp_ready[cyc] = ready;
    endtask

    // Each word: 4 accepted bytes (optionally preceded by idle gaps), then one write cycle.
    task automatic do_load(input int len_in, input int gap, input int abort_w, input int abort_b,
                           input bit probe, input bit simul, output int start_c);
        int        n;
        bit [31:0] word;
        start_c        = cyc;
        bus.ld_start   = 1'b1;
        bus.ld_len     = (AW+1)'(len_in);
        exp_stall[cyc] = 1'b1;
        if (simul) begin
            bus.cpu_req = 1'b1;
            bus.cpu_pc  = 32'h8;
        end
        step();
        n = (len_in > 64) ? 64 : len_in;
        for (int w = 0; w < n; w++) begin
            word = '0;
            for (int b = 0; b < 4; b++) begin
                for (int g = 0; g < gap; g++) begin
                    mark_load(1'b1);
                    if (probe && w == 0 && b == 1 && g == 0) begin
                        bus.ld_start = 1'b1;
                        bus.ld_len   = (AW+1)'(1);
                        bus.cpu_req  = 1'b1;
                        bus.cpu_pc   = 32'h0;
                    end
                    step();
                end
                if (w == abort_w && b == abort_b) begin
                    reset_n = 1'b0;
                    mark_load(1'b1);
                    step();
                    reset_n = 1'b1;
                    return;
                end
                mark_load(1'b1);
                bus.ld_byte_valid = 1'b1;
                bus.ld_byte       = src[4*w+b];
                word[8*b +: 8]    = src[4*w+b];
                step();
            end
            mark_load(1'b0);
            bus.ld_byte_valid = 1'b1;
            bus.ld_byte       = 8'hAA;
            exp_we[cyc]       = 1'b1;
            exp_addr[cyc]     = w[AW-1:0];
            exp_wdata[cyc]    = word;
            ref_mem[w]        = word;
            step();
        end
        exp_done[cyc]  = 1'b1;
        exp_busy[cyc]  = 1'b1;
        exp_stall[cyc] = 1'b1;
        step();
    endtask

    initial begin
        int t, s, we0, dn0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        bus.cpu_req = 1'b0; bus.cpu_pc = '0; bus.ld_start = 1'b0; bus.ld_len = '0;
        bus.ld_byte = '0; bus.ld_byte_valid = 1'b0;

        // Reset values.
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_cpu_valid", 32'(bus.cpu_valid), 32'd0);
        check("rst_cpu_instr", bus.cpu_instr, 32'd0);
        check("rst_cpu_fault", 32'(bus.cpu_fault), 32'd0);
        check("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        check("rst_ld_busy", 32'(bus.ld_busy), 32'd0);
        check("rst_ld_done", 32'(bus.ld_done), 32'd0);
        check("rst_ld_ready", 32'(bus.ld_byte_ready), 32'd0);
        check("rst_mem_re", 32'(bus.mem_re), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        bus.ld_start = 1'b1;
        #1;
        check("rst_stall_ld_start", 32'(bus.cpu_stall), 32'd1);
        bus.ld_start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        cyc     = 0;

        // Fetch stream over the preloaded program.
        step();
        t = cyc;
        fetch(32'h0); fetch(32'h4); fetch(32'h8); step();
        check("fetch0_lit", obs_instr[t+1], 32'hE04F000F);
        check("fetch4_lit", obs_instr[t+2], 32'hE2800001);
        check("fetch8_lit", obs_instr[t+3], 32'hE1500001);

        // Out-of-range and misaligned fetches.
        t = cyc;
        fetch(32'h100); fetch(32'h2); step();
        check("oor_instr_lit", obs_instr[t+1], NOP);
        check("oor_fault_lit", 32'(obs_fault[t+1]), 32'd1);
        check("mis_instr_lit", obs_instr[t+2], NOP);
        check("mis_fault_lit", 32'(obs_fault[t+2]), 32'd1);

        // 2-word load started together with a fetch, right after a fetch.
        src[0] = 8'h0F; src[1] = 8'h00; src[2] = 8'h4F; src[3] = 8'hE0;
        src[4] = 8'h01; src[5] = 8'h00; src[6] = 8'h80; src[7] = 8'hE2;
        fetch(32'h4);
        we0 = we_total;
        do_load(2, 0, -1, -1, 1'b0, 1'b1, s);
        check("prev_fetch_valid_lit", 32'(obs_valid[s]), 32'd1);
        check("prev_fetch_instr_lit", obs_instr[s], 32'hE2800001);
        check("blocked_fetch_lit", 32'(obs_valid[s+1]), 32'd0);
        check("w0_write_lit", obs_wdata[s+5], 32'hE04F000F);
        check("w1_write_lit", obs_wdata[s+10], 32'hE2800001);
        check("load2_done_lat", 32'(last_done_cyc - s), 32'd11);
        check("load2_writes", 32'(we_total - we0), 32'd2);

        // 3-word load with byte gaps and an ignored ld_start/cpu_req mid-load.
        for (int k = 0; k < 12; k++) src[k] = 8'(8'h10 + k);
        dn0 = done_total;
        do_load(3, 2, -1, -1, 1'b1, 1'b0, s);
        check("gap_done_lat", 32'(last_done_cyc - s), 32'd40);
        check("gap_single_done", 32'(done_total - dn0), 32'd1);
        t = cyc;
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC); step();
        check("gap_w0_lit", obs_instr[t+1], 32'h13121110);
        check("gap_w1_lit", obs_instr[t+2], 32'h17161514);
        check("gap_w2_lit", obs_instr[t+3], 32'h1B1A1918);
        check("gap_w3_lit", obs_instr[t+4], 32'hC0DE0003);

        // Zero-length load.
        we0 = we_total;
        do_load(0, 0, -1, -1, 1'b0, 1'b0, s);
        check("len0_done_lat", 32'(last_done_cyc - s), 32'd1);
        check("len0_writes", 32'(we_total - we0), 32'd0);

        // Oversized length clamps to the memory depth.
        for (int k = 0; k < 256; k++) src[k] = 8'(k) ^ 8'h5C;
        we0 = we_total;
        do_load(127, 0, -1, -1, 1'b0, 1'b0, s);
        check("clamp_writes", 32'(we_total - we0), 32'd64);
        check("clamp_done_lat", 32'(last_done_cyc - s), 32'd321);
        t = cyc;
        fetch(32'hFC); fetch(32'h80); step();
        check("clamp_w63_lit", obs_instr[t+1], 32'hA3A2A1A0);
        check("clamp_w32_lit", obs_instr[t+2], 32'hDFDEDDDC);

        // Reset after two bytes of word 1.
        for (int k = 0; k < 12; k++) src[k] = 8'(8'h60 + k);
        we0 = we_total;
        dn0 = done_total;
        do_load(3, 0, 1, 2, 1'b0, 1'b0, s);
        t = cyc;
        fetch(32'h0); fetch(32'h4); step();
        check("abort_writes", 32'(we_total - we0), 32'd1);
        check("abort_no_done", 32'(done_total - dn0), 32'd0);
        check("abort_w0_lit", obs_instr[t+1], 32'h63626160);
        check("abort_w1_lit", obs_instr[t+2], 32'h5B5A5958);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
